kbonacci_gen: RTL
=================

# kbonacci_gen

Clocked, parametrised successor to the dual-rail Fibonacci generator. Produces an order-K additive recurrence (K=2 Fibonacci, K=3 Tribonacci, …) from a common seed. Terms leave on a single-beat valid/ack link with back-pressure. Term count and overflow reporting are programmable. Sits as a synchronous test-pattern and arithmetic-load source beside the asynchronous cores.

## Interface
- WIDTH, 32, term width in bits
- ORDER, 2, recurrence order K (legal 2..8); each new term is the sum of the previous K terms
- SEED, 1, value of the first K terms
- CNT_W, 16, width of the term counter and index
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  start a sequence; sampled only in IDLE
- count_i  in  CNT_W  number of terms to emit, latched at start; 0 = unbounded
- ack_i  in  1  consumer accepts the current term this cycle
- valid_o  out  1  out/idx_o hold a valid term
- out  out  WIDTH  current term
- idx_o  out  CNT_W  index of the current term (first term = 0)
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse when a sequence ends
- ovf_o  out  1  sticky overflow flag, cleared by start

## Operation
- States: IDLE, RUN, DONE (enum in package).
- IDLE: valid_o=0. On start=1: latch count_i, load all K window registers with SEED, out=SEED, idx_o=0, clear ovf_o, go to RUN.
- RUN: valid_o=1. Beat = valid_o & ack_i. On a beat:
  - If idx_o+1 == count (count≠0), go to DONE.
  - Otherwise compute the next term: SEED while idx_o+1 < K, else the sum of the K window registers.
  - Shift the window (oldest term dropped). Load out, increment idx_o.
- Sum is formed at full width WIDTH+$clog2(ORDER). Overflow = any bit above WIDTH-1 nonzero.
- Without a beat, out, idx_o and the window hold; there are no spurious updates.
- DONE: done_o=1 for exactly one cycle, valid_o=0, then IDLE.
- Unbounded mode: idx_o wraps 2^CNT_W-1 → 0 and the sequence continues; the wrap is not an error.
- start outside IDLE is ignored.

## Timing
- Reset values: valid_o=0, out=0, idx_o=0, busy_o=0, done_o=0, ovf_o=0; state IDLE.
- start at edge n: valid_o=1 with term 0 visible after edge n.
- Throughput is one term per cycle while ack_i is held high. A beat at edge m shows the next term after edge m (zero bubble).
- After the last beat at edge m: valid_o=0 and done_o=1 after edge m; IDLE after edge m+1. A start is accepted from edge m+2.
- rst mid-sequence: all outputs return to reset values at the same edge; no done_o pulse.
- rst and start asserted together: rst wins.
- ack_i while valid_o=0 is ignored.

## Configuration
- Macro KBONACCI_OVF_HALT_EN controls what happens when the sum overflows.
- Defined: the overflowing term is not emitted. ovf_o=1, valid_o drops, and the state goes to DONE (done_o pulse) on the same edge the beat is taken.
- Undefined: the term is emitted truncated to WIDTH (mod 2^WIDTH), ovf_o sets sticky, and the sequence continues.

## Structure
- Package kbonacci_pkg holds:
  - state_t enum {IDLE, RUN, DONE}
  - localparam function sum_w(WIDTH, ORDER) = WIDTH+$clog2(ORDER)
  - a legality check on ORDER
- Sub-module kbon_tap_sum: combinational K-input adder over the window, output at sum_w bits, plus an overflow bit. The top level holds the FSM, window shift register, counters and handshake.

## Test plan
- WIDTH=32, ORDER=2, SEED=1, count_i=10, ack_i held high -> out 1,1,2,3,5,8,13,21,34,55 on 10 consecutive cycles; idx_o 0..9; done_o pulses once; ovf_o=0.
- ORDER=3, count_i=8, ack_i toggling every other cycle -> out 1,1,1,3,5,9,17,31; each value holds stable while ack_i=0; 8 beats total.
- WIDTH=8, ORDER=2, count_i=0:
  - Without the macro: idx 12 = 233, idx 13 = 121 (377 mod 256), ovf_o=1 from that cycle; idx 14 = 98 (233+121 mod 256).
  - With KBONACCI_OVF_HALT_EN: last emitted term is 233 at idx 12; done_o pulses after that beat; ovf_o=1.
- Apply rst at term idx 4 mid-RUN -> all outputs 0 next cycle, no done_o. A following start restarts at idx 0 with out=1.
- Assert start repeatedly during RUN -> ignored; the sequence and idx_o continue unchanged.
- CNT_W=4, count_i=0, ORDER=2, SEED=0 -> out stays 0; idx_o wraps 15→0; valid_o stays 1; no done_o; ovf_o=0.

Source files
------------

// File: rtl/kbonacci_pkg.sv
// -----------------------------------------------------------------------------
// kbonacci_pkg
// Shared types and helpers for the order-K additive recurrence generator.
//   state_t  : FSM state encoding (IDLE, RUN, DONE)
//   sum_w    : width of the full-precision window sum (WIDTH + clog2(ORDER))
//   order_ok : legality check for the recurrence order (2..8)
// -----------------------------------------------------------------------------
package kbonacci_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ORDER_MIN = 2;
  localparam int ORDER_MAX = 8;

  // Width needed to hold the sum of ORDER terms of WIDTH bits without loss.
  function automatic int sum_w(input int width, input int order);
    return width + $clog2(order);
  endfunction

  function automatic bit order_ok(input int order);
    return (order >= ORDER_MIN) && (order <= ORDER_MAX);
  endfunction

endpackage

// File: rtl/kbonacci_if.sv
// -----------------------------------------------------------------------------
// kbonacci_if
// Single-beat valid/ack term link.
//   valid_o : producer holds a valid term
//   out     : term value (WIDTH bits)
//   idx_o   : term index (CNT_W bits)
//   ack_i   : consumer accepts the term this cycle
// master = producer (generator), slave = consumer.
// -----------------------------------------------------------------------------
interface kbonacci_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             valid_o;
  logic             ack_i;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] idx_o;

  modport master (output valid_o, output out, output idx_o, input ack_i);
  modport slave  (input valid_o, input out, input idx_o, output ack_i);
endinterface

// File: rtl/kbon_tap_sum.sv
// -----------------------------------------------------------------------------
// kbon_tap_sum
// Combinational ORDER-input adder over the recurrence window.
//   win_i  : ORDER terms of WIDTH bits
//   sum_o  : full-precision sum, sum_w(WIDTH, ORDER) bits
//   ovf_o  : any sum bit above WIDTH-1 is set
// -----------------------------------------------------------------------------
module kbon_tap_sum
  import kbonacci_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ORDER = 2
) (
  input  logic [ORDER-1:0][WIDTH-1:0]     win_i,
  output logic [sum_w(WIDTH, ORDER)-1:0]  sum_o,
  output logic                            ovf_o
);

  localparam int SW = sum_w(WIDTH, ORDER);

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < ORDER; i++) begin
      sum_o = sum_o + SW'(win_i[i]);
    end
    ovf_o = |sum_o[SW-1:WIDTH];
  end

endmodule

// File: rtl/kbonacci_gen.sv
// -----------------------------------------------------------------------------
// kbonacci_gen
// Order-K additive recurrence generator (K=2 Fibonacci, K=3 Tribonacci, ...).
// The first ORDER terms equal SEED; each later term is the sum of the previous
// ORDER terms. Terms leave on a valid/ack link with back-pressure.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : start a sequence (only honoured in IDLE)
//   count_i  : number of terms to emit, latched at start; 0 = unbounded
//   term_if  : kbonacci_if.master (valid_o, out, idx_o, ack_i)
//   busy_o   : high in RUN
//   done_o   : one-cycle pulse when a sequence ends
//   ovf_o    : sticky sum overflow flag, cleared by start
//
// Build option KBONACCI_OVF_HALT_EN:
//   defined   - an overflowing term is not emitted; the sequence ends instead.
//   undefined - the term is emitted truncated to WIDTH and the sequence goes on.
// -----------------------------------------------------------------------------
module kbonacci_gen
  import kbonacci_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ORDER = 2,
  parameter int SEED  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count_i,
  kbonacci_if.master       term_if,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  localparam int                SW     = sum_w(WIDTH, ORDER);
  localparam logic [WIDTH-1:0]  SEED_W = WIDTH'(SEED);

  if (!order_ok(ORDER)) begin : g_bad_order
    $error("kbonacci_gen: ORDER must lie in 2..8");
  end

  state_t                     state_q, state_d;
  logic [ORDER-1:0][WIDTH-1:0] win_q, win_d;     // win_q[0] is the newest term
  logic [WIDTH-1:0]           out_q, out_d;
  logic [CNT_W-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  // Seed terms still to emit after the current one. A counter rather than an
  // idx compare, so that idx wrap in unbounded mode never re-enters seeding.
  logic [3:0]                 seeds_q, seeds_d;

  logic [SW-1:0]              sum;
  logic                       sum_ovf;
  logic                       beat, last, seed_phase, term_ovf, advance;
  logic [CNT_W-1:0]           idx_inc;
  logic [WIDTH-1:0]           next_term;

  kbon_tap_sum #(.WIDTH(WIDTH), .ORDER(ORDER)) u_tap_sum (
    .win_i (win_q),
    .sum_o (sum),
    .ovf_o (sum_ovf)
  );

  assign beat       = (state_q == RUN) && term_if.ack_i;
  assign idx_inc    = idx_q + 1'b1;
  assign last       = (cnt_q != '0) && (idx_inc == cnt_q);
  assign seed_phase = (seeds_q != '0);
  assign next_term  = seed_phase ? SEED_W : sum[WIDTH-1:0];
  assign term_ovf   = !seed_phase && sum_ovf;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    out_d   = out_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    seeds_d = seeds_q;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = count_i;
          win_d   = {ORDER{SEED_W}};
          out_d   = SEED_W;
          idx_d   = '0;
          ovf_d   = 1'b0;
          seeds_d = 4'(ORDER - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (beat) begin
          if (last) begin
            state_d = DONE;
          end else begin
            if (term_ovf) ovf_d = 1'b1;
`ifdef KBONACCI_OVF_HALT_EN
            if (term_ovf) state_d = DONE;
            else          advance = 1'b1;
`else
            advance = 1'b1;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      win_d = {win_q[ORDER-2:0], next_term};
      out_d = next_term;
      idx_d = idx_inc;
      if (seed_phase) seeds_d = seeds_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      seeds_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      seeds_q <= seeds_d;
    end
  end

  assign term_if.valid_o = (state_q == RUN);
  assign term_if.out     = out_q;
  assign term_if.idx_o   = idx_q;
  assign busy_o          = (state_q == RUN);
  assign done_o          = (state_q == DONE);
  assign ovf_o           = ovf_q;

endmodule
